pc_unit: RTL and testbench
==========================

// Module: pc_unit
// PURPOSE
//  Parametrised program-counter unit for the fetch stage; replaces the fixed 16-bit PC register.
//  Holds the current fetch address and selects the next one each cycle: increment, stall, branch, jump, call or return.
//  Adds a boot/run/halt state machine and an optional return-address stack.
//  Drives the instruction-memory address and the fetch-valid qualifier.
// PARAMETERS
//  PC_W       16    PC width in bits
//  INC        1     sequential increment (address units per instruction)
//  RESET_VEC  0     PC value loaded at reset
//  RAS_DEPTH  4     return-stack entries (power of 2, >=2); used only with PC_RAS_EN
// PORTS
//  clk            in   1     rising-edge clock
//  reset          in   1     asynchronous, active-low reset
//  stall          in   1     hold PC (pipeline stall / imem not ready)
//  halt           in   1     enter HALT after the current cycle
//  br_taken       in   1     branch resolved taken (flush redirect)
//  br_target      in   PC_W  branch target
//  jmp            in   1     jump from decode
//  jmp_target     in   PC_W  jump/call target
//  call           in   1     qualifies jmp: also push link_addr
//  link_addr      in   PC_W  return address for call
//  ret            in   1     return from decode
//  ret_target     in   PC_W  return address from register file (fallback)
//  pc             out  PC_W  current fetch address (registered)
//  pc_plus        out  PC_W  pc+INC (combinational, mod 2^PC_W)
//  pc_valid       out  1     pc is a valid fetch address this cycle
//  halted         out  1     FSM in HALT
//  ras_overflow   out  1     sticky: push onto full stack
//  ras_underflow  out  1     one-cycle pulse: ret with empty stack
// BEHAVIOUR
//  Reset (reset=0, async): pc=RESET_VEC, pc_valid=0, halted=0, state=BOOT, stack empty, both ras flags 0.
//  FSM BOOT->RUN on first clk after reset release; pc held at RESET_VEC; pc_valid=1 from RUN onward.
//  RUN->HALT when halt=1 and no br_taken that cycle; pc frozen; pc_valid=0, halted=1.
//  HALT->RUN only on br_taken: pc<=br_target. All other inputs are ignored in HALT.
//  RUN next-PC priority, evaluated per rising edge:
//   1 br_taken        pc<=br_target (overrides stall, jmp, ret)
//   2 stall           pc held; jmp/call/ret ignored (decode re-presents them)
//   3 ret             pc<=popped top, or ret_target if stack empty / feature off
//   4 jmp             pc<=jmp_target; if call, push link_addr
//   5 otherwise       pc<=pc+INC, wraps modulo 2^PC_W (0xFFFF+1 -> 0x0000 at PC_W=16)
//  Stack actions are suppressed whenever priority 1 or 2 wins.
//  ret and jmp both asserted: ret wins; call ignored.
//  Latency: redirect visible on pc one cycle after the input edge; no bubbles are inserted by this block.
//  Reset asserted mid-operation returns to BOOT immediately, regardless of clk.
// CONFIGURATION
//  PC_RAS_EN defined: stack of RAS_DEPTH x PC_W entries with a circular pointer.
//   - Push when full overwrites the oldest entry and sets ras_overflow (cleared only by reset).
//   - Pop when empty uses ret_target and pulses ras_underflow for one cycle.
//   - Count saturates at 0 and RAS_DEPTH.
//  PC_RAS_EN undefined: no storage; ret always uses ret_target; ras_overflow=ras_underflow=0.
// STRUCTURE
//  Package pc_pkg:
//   - FSM state encoding: BOOT=2'b00, RUN=2'b01, HALT=2'b10.
//   - Next-PC select encoding: SEL_HOLD, SEL_INC, SEL_BR, SEL_JMP, SEL_RET.
//   - Default localparams.
//  Sub-module pc_ras (RAS_DEPTH, PC_W): push/pop/empty/full/top plus overflow flag; instantiated only under PC_RAS_EN.
//  Top level: FSM, priority mux and PC register.
// TESTING
//  T1 reset low mid-run, release -> pc=RESET_VEC, pc_valid=0 for 1 cycle, then pc 0,1,2,3 with INC=1.
//  T2 pc=0xFFFE, INC=1, 3 free cycles -> pc 0xFFFF, 0x0000, 0x0001.
//  T3 stall=1 with jmp=1, jmp_target=0x0040 -> pc held, no push.
//     Same cycle plus br_taken=1, br_target=0x0100 -> pc=0x0100.
//  T4 call to 0x0200 with link 0x0011, then ret -> pc=0x0200, then 0x0011.
//     Next ret on empty stack, ret_target=0x0033 -> pc=0x0033, ras_underflow pulse.
//  T5 five calls with RAS_DEPTH=4 (links 1..5) -> ras_overflow=1; four rets give 5,4,3,2; fifth ret uses ret_target.
//  T6 halt=1 -> halted=1, pc frozen 10 cycles with jmp toggling; br_taken to 0x0080 -> RUN, pc=0x0080.
//     Rerun T4/T5 with PC_RAS_EN undefined -> every ret uses ret_target, flags stay 0.

Source files
------------

// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared types and default parameters for the program-counter unit
package pc_pkg;

    localparam int DEF_PC_W      = 16;
    localparam int DEF_INC       = 1;
    localparam int DEF_RESET_VEC = 0;
    localparam int DEF_RAS_DEPTH = 4;

    typedef enum logic [1:0] {
        BOOT = 2'b00,
        RUN  = 2'b01,
        HALT = 2'b10
    } pc_state_t;

    typedef enum logic [2:0] {
        SEL_HOLD,
        SEL_INC,
        SEL_BR,
        SEL_JMP,
        SEL_RET
    } pc_sel_t;

endpackage

// File: rtl/pc_ras.sv
// rtl/pc_ras.sv - circular return-address stack with saturating count and overflow/underflow flags
module pc_ras #(
    parameter int RAS_DEPTH = 4,
    parameter int PC_W      = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            push,
    input  logic            pop,
    input  logic [PC_W-1:0] push_data,
    output logic [PC_W-1:0] top,
    output logic            empty,
    output logic            full,
    output logic            overflow,
    output logic            underflow
);

    localparam int PTR_W = $clog2(RAS_DEPTH);

    logic [PC_W-1:0]  mem [RAS_DEPTH];
    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] top_idx;
    logic [PTR_W:0]   count;

    assign top_idx = ptr - PTR_W'(1);
    assign top     = mem[top_idx];
    assign empty   = (count == '0);
    assign full    = (count == (PTR_W+1)'(RAS_DEPTH));

    // Entry storage: a push always writes at ptr, which is the oldest slot once the stack is full
    always_ff @(posedge clk) begin
        if (push) begin
            mem[ptr] <= push_data;
        end
    end

    // Pointer, saturating count, sticky overflow and one-cycle underflow pulse
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr       <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            underflow <= pop && empty;
            if (push) begin
                ptr <= ptr + PTR_W'(1);
                if (full) begin
                    overflow <= 1'b1;
                end else begin
                    count <= count + (PTR_W+1)'(1);
                end
            end else if (pop && !empty) begin
                ptr   <= ptr - PTR_W'(1);
                count <= count - (PTR_W+1)'(1);
            end
        end
    end

endmodule

// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - fetch-stage program counter with boot/run/halt FSM; optional return stack under PC_RAS_EN
module pc_unit
    import pc_pkg::*;
#(
    parameter int PC_W      = DEF_PC_W,
    parameter int INC       = DEF_INC,
    parameter int RESET_VEC = DEF_RESET_VEC,
    parameter int RAS_DEPTH = DEF_RAS_DEPTH
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            halt,
    input  logic            br_taken,
    input  logic [PC_W-1:0] br_target,
    input  logic            jmp,
    input  logic [PC_W-1:0] jmp_target,
    input  logic            call,
    input  logic [PC_W-1:0] link_addr,
    input  logic            ret,
    input  logic [PC_W-1:0] ret_target,
    output logic [PC_W-1:0] pc,
    output logic [PC_W-1:0] pc_plus,
    output logic            pc_valid,
    output logic            halted,
    output logic            ras_overflow,
    output logic            ras_underflow
);

    pc_state_t       state;
    pc_state_t       state_next;
    pc_sel_t         sel;
    logic            ras_push;
    logic            ras_pop;
    logic [PC_W-1:0] ret_addr;
    logic [PC_W-1:0] pc_next;

    assign pc_plus  = pc + PC_W'(INC);
    assign pc_valid = (state == RUN);
    assign halted   = (state == HALT);

`ifdef PC_RAS_EN
    logic [PC_W-1:0] ras_top;
    logic            ras_empty;
    logic            ras_full;

    pc_ras #(
        .RAS_DEPTH (RAS_DEPTH),
        .PC_W      (PC_W)
    ) u_ras (
        .clk       (clk),
        .reset     (reset),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (link_addr),
        .top       (ras_top),
        .empty     (ras_empty),
        .full      (ras_full),
        .overflow  (ras_overflow),
        .underflow (ras_underflow)
    );

    // An empty stack falls back to the register-file return address
    assign ret_addr = ras_empty ? ret_target : ras_top;

    logic unused_ras;
    assign unused_ras = ras_full;
`else
    assign ret_addr      = ret_target;
    assign ras_overflow  = 1'b0;
    assign ras_underflow = 1'b0;

    logic unused_ras;
    assign unused_ras = ^{ras_push, ras_pop, call, link_addr};
`endif

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= BOOT;
        end else begin
            state <= state_next;
        end
    end

    // Next state, next-PC select and stack strobes; redirect beats halt, halt beats stall, ret beats jmp
    always_comb begin
        state_next = state;
        sel        = SEL_HOLD;
        ras_push   = 1'b0;
        ras_pop    = 1'b0;
        case (state)
            BOOT: begin
                state_next = RUN;
            end
            RUN: begin
                if (br_taken) begin
                    sel = SEL_BR;
                end else if (halt) begin
                    state_next = HALT;
                end else if (stall) begin
                    sel = SEL_HOLD;
                end else if (ret) begin
                    sel     = SEL_RET;
                    ras_pop = 1'b1;
                end else if (jmp) begin
                    sel      = SEL_JMP;
                    ras_push = call;
                end else begin
                    sel = SEL_INC;
                end
            end
            HALT: begin
                if (br_taken) begin
                    sel        = SEL_BR;
                    state_next = RUN;
                end
            end
            default: begin
                state_next = BOOT;
            end
        endcase
    end

    // Next-PC mux
    always_comb begin
        pc_next = pc;
        case (sel)
            SEL_INC:  pc_next = pc_plus;
            SEL_BR:   pc_next = br_target;
            SEL_JMP:  pc_next = jmp_target;
            SEL_RET:  pc_next = ret_addr;
            default:  pc_next = pc;
        endcase
    end

    // PC register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc <= PC_W'(RESET_VEC);
        end else begin
            pc <= pc_next;
        end
    end

endmodule

// File: tb/tb_pc_unit.sv
// tb/tb_pc_unit.sv - directed self-checking bench for pc_unit (expectations follow PC_RAS_EN)
module tb_pc_unit;

`ifdef PC_RAS_EN
    localparam bit RAS = 1'b1;
`else
    localparam bit RAS = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        stall;
    logic        halt;
    logic        br_taken;
    logic [15:0] br_target;
    logic        jmp;
    logic [15:0] jmp_target;
    logic        call;
    logic [15:0] link_addr;
    logic        ret;
    logic [15:0] ret_target;
    logic [15:0] pc;
    logic [15:0] pc_plus;
    logic        pc_valid;
    logic        halted;
    logic        ras_overflow;
    logic        ras_underflow;

    int vectors;
    int miscompares;

    pc_unit #(
        .PC_W      (16),
        .INC       (1),
        .RESET_VEC (0),
        .RAS_DEPTH (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .halt          (halt),
        .br_taken      (br_taken),
        .br_target     (br_target),
        .jmp           (jmp),
        .jmp_target    (jmp_target),
        .call          (call),
        .link_addr     (link_addr),
        .ret           (ret),
        .ret_target    (ret_target),
        .pc            (pc),
        .pc_plus       (pc_plus),
        .pc_valid      (pc_valid),
        .halted        (halted),
        .ras_overflow  (ras_overflow),
        .ras_underflow (ras_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [15:0] frozen;
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b0;
        stall       = 1'b0;
        halt        = 1'b0;
        br_taken    = 1'b0;
        br_target   = '0;
        jmp         = 1'b0;
        jmp_target  = '0;
        call        = 1'b0;
        link_addr   = '0;
        ret         = 1'b0;
        ret_target  = '0;

        step();
        step();
        check("rst_pc", pc, 16'h0000);
        check("rst_valid", pc_valid, 1'b0);
        check("rst_halted", halted, 1'b0);
        check("rst_ovf", ras_overflow, 1'b0);
        check("rst_unf", ras_underflow, 1'b0);

        reset = 1'b1;
        step();
        check("boot_pc", pc, 16'h0000);
        check("boot_valid", pc_valid, 1'b1);
        step();
        step();
        step();
        check("run_pc3", pc, 16'h0003);

        // T1: asynchronous reset mid-cycle, then release
        #2 reset = 1'b0;
        #1;
        check("t1_async_pc", pc, 16'h0000);
        check("t1_async_valid", pc_valid, 1'b0);
        step();
        reset = 1'b1;
        check("t1_boot_valid", pc_valid, 1'b0);
        step();
        check("t1_pc0", pc, 16'h0000);
        check("t1_valid", pc_valid, 1'b1);
        for (int i = 1; i <= 3; i++) begin
            step();
            check("t1_seq", pc, 32'(i));
        end

        // T2: wrap at the top of the address space
        jmp        = 1'b1;
        jmp_target = 16'hFFFE;
        step();
        jmp = 1'b0;
        check("t2_jmp", pc, 16'hFFFE);
        step();
        check("t2_ffff", pc, 16'hFFFF);
        check("t2_plus_wrap", pc_plus, 16'h0000);
        step();
        check("t2_wrap", pc, 16'h0000);
        step();
        check("t2_after", pc, 16'h0001);

        // T3: stall blocks jmp/call, branch overrides stall
        stall      = 1'b1;
        jmp        = 1'b1;
        call       = 1'b1;
        jmp_target = 16'h0040;
        link_addr  = 16'h0077;
        step();
        check("t3_stall_hold", pc, 16'h0001);
        br_taken  = 1'b1;
        br_target = 16'h0100;
        step();
        check("t3_br_over_stall", pc, 16'h0100);
        stall    = 1'b0;
        jmp      = 1'b0;
        call     = 1'b0;
        br_taken = 1'b0;

        // T4: call/ret, then ret on empty stack
        jmp        = 1'b1;
        call       = 1'b1;
        jmp_target = 16'h0200;
        link_addr  = 16'h0011;
        step();
        check("t4_call", pc, 16'h0200);
        jmp        = 1'b0;
        call       = 1'b0;
        ret        = 1'b1;
        ret_target = 16'h0022;
        step();
        check("t4_ret", pc, RAS ? 32'h0011 : 32'h0022);
        check("t4_no_unf", ras_underflow, 1'b0);
        ret_target = 16'h0033;
        step();
        check("t4_ret_empty", pc, 16'h0033);
        check("t4_unf_pulse", ras_underflow, RAS);
        ret = 1'b0;
        step();
        check("t4_unf_clear", ras_underflow, 1'b0);
        check("t4_inc", pc, 16'h0034);

        // T5: overfill the stack, then drain it
        for (int i = 1; i <= 5; i++) begin
            jmp        = 1'b1;
            call       = 1'b1;
            jmp_target = 16'h0300 + 16'(i);
            link_addr  = 16'(i);
            step();
        end
        jmp  = 1'b0;
        call = 1'b0;
        check("t5_call5_pc", pc, 16'h0305);
        check("t5_ovf", ras_overflow, RAS);
        ret        = 1'b1;
        ret_target = 16'h0044;
        for (int i = 5; i >= 2; i--) begin
            step();
            check("t5_ret", pc, RAS ? 32'(i) : 32'h0044);
        end
        step();
        check("t5_ret_fallback", pc, 16'h0044);
        check("t5_unf", ras_underflow, RAS);
        check("t5_ovf_sticky", ras_overflow, RAS);
        ret = 1'b0;

        // halt and branch in the same cycle: branch wins, no halt
        halt      = 1'b1;
        br_taken  = 1'b1;
        br_target = 16'h0090;
        step();
        check("hb_pc", pc, 16'h0090);
        check("hb_halted", halted, 1'b0);
        br_taken = 1'b0;

        // T6: halt, inputs ignored, branch resumes
        frozen = pc;
        step();
        halt = 1'b0;
        check("t6_halted", halted, 1'b1);
        check("t6_valid", pc_valid, 1'b0);
        check("t6_frozen", pc, frozen);
        jmp_target = 16'h0555;
        for (int i = 0; i < 10; i++) begin
            jmp   = ~jmp;
            ret   = jmp;
            stall = ~jmp;
            step();
            check("t6_hold", pc, frozen);
        end
        check("t6_still_halted", halted, 1'b1);
        jmp       = 1'b0;
        ret       = 1'b0;
        stall     = 1'b0;
        br_taken  = 1'b1;
        br_target = 16'h0080;
        step();
        br_taken = 1'b0;
        check("t6_resume_pc", pc, 16'h0080);
        check("t6_resume_halted", halted, 1'b0);
        check("t6_resume_valid", pc_valid, 1'b1);
        step();
        check("t6_resume_inc", pc, 16'h0081);

        // reset clears the sticky overflow flag
        #2 reset = 1'b0;
        #1;
        check("end_rst_ovf", ras_overflow, 1'b0);
        check("end_rst_pc", pc, 16'h0000);
        reset = 1'b1;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
